// File: rtl/hazard_pkg.sv
// Shared sizing defaults and state encoding for the register hazard scoreboard.
package hazard_pkg;

    localparam int NREGS = 16;
    localparam int TAGW  = 4;
    localparam int CNTW  = 2;

    typedef logic [TAGW-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sb_state_t;

endpackage

// File: rtl/sb_counter.sv
// Outstanding-write counter for one architectural register: summed inc/dec per cycle,
// clamped at 0 (flagging underflow) and at its maximum.
module sb_counter #(
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            dec_a,
    input  logic            dec_b,
    output logic [CNTW-1:0] cnt,
    output logic            nz,
    output logic            at_max,
    output logic            underflow
);
    import hazard_pkg::*;

    localparam int SW = CNTW + 2;
    localparam logic [CNTW-1:0] MAXV = '1;

    logic [CNTW-1:0]       r_cnt;
    logic                  r_nz;
    logic signed [SW-1:0]  w_sum;
    logic [CNTW-1:0]       w_next;

    // Net change is signed so a simultaneous inc/dec cancels before any clamping.
    always_comb begin
        w_sum = $signed({2'b00, r_cnt}) + $signed(SW'(inc))
              - $signed(SW'(dec_a)) - $signed(SW'(dec_b));
        if (w_sum < 0)
            w_next = '0;
        else if (w_sum > $signed(SW'(MAXV)))
            w_next = MAXV;
        else
            w_next = w_sum[CNTW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_nz  <= 1'b0;
        end else begin
            r_cnt <= w_next;
            r_nz  <= (w_next != '0);
        end
    end

    assign cnt       = r_cnt;
    assign nz        = r_nz;
    assign at_max    = (r_cnt == MAXV);
    assign underflow = (w_sum < 0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: counts in-flight writes per register and stalls Decode.
// Optional `SCOREBOARD_FWD_EN adds Execute-forwarding bypass of single-pending sources.
module hazard_scoreboard #(
    parameter int NREGS = 16,
    parameter int TAGW  = 4,
    parameter int CNTW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic             issue_we,
    input  logic [TAGW-1:0]  issue_wa3,
    input  logic [TAGW-1:0]  ra1d,
    input  logic [TAGW-1:0]  ra2d,
    input  logic             use1,
    input  logic             use2,
    input  logic             retire_valid,
    input  logic [TAGW-1:0]  retire_wa3,
    input  logic             squash_valid,
    input  logic [TAGW-1:0]  squash_wa3,
    input  logic             drain_req,
`ifdef SCOREBOARD_FWD_EN
    input  logic             exe_fwd_valid,
    input  logic [TAGW-1:0]  exe_fwd_wa3,
`endif
    output logic             stallD,
    output logic [NREGS-1:0] busy,
    output logic             drain_done,
    output logic             err
);
    import hazard_pkg::*;

    logic [CNTW-1:0]  w_cnt [NREGS];
    logic [NREGS-1:0] w_nz;
    logic [NREGS-1:0] w_max;
    logic [NREGS-1:0] w_uf;
    logic             w_pend1;
    logic             w_pend2;
    logic             w_accept;
    sb_state_t        r_state;
    sb_state_t        w_state_next;
    logic             r_err;

    for (genvar i = 0; i < NREGS; i++) begin : g_cnt
        sb_counter #(.CNTW(CNTW)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (w_accept && (issue_wa3 == TAGW'(i))),
            .dec_a     (retire_valid && (retire_wa3 == TAGW'(i))),
            .dec_b     (squash_valid && (squash_wa3 == TAGW'(i))),
            .cnt       (w_cnt[i]),
            .nz        (w_nz[i]),
            .at_max    (w_max[i]),
            .underflow (w_uf[i])
        );
    end

    always_comb begin
        w_pend1 = use1 && w_nz[ra1d];
        w_pend2 = use2 && w_nz[ra2d];
`ifdef SCOREBOARD_FWD_EN
        // The single outstanding write is in Execute right now, so it can be bypassed.
        if (exe_fwd_valid && (ra1d == exe_fwd_wa3) && (w_cnt[ra1d] == CNTW'(1)))
            w_pend1 = 1'b0;
        if (exe_fwd_valid && (ra2d == exe_fwd_wa3) && (w_cnt[ra2d] == CNTW'(1)))
            w_pend2 = 1'b0;
`endif
    end

    assign stallD   = w_pend1 || w_pend2 || (issue_we && w_max[issue_wa3]) || (r_state != RUN);
    assign w_accept = issue_valid && issue_we && !stallD;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_err   <= r_err || (|w_uf);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (drain_req) w_state_next = DRAIN;
            DRAIN:   if ((w_nz == '0) && !w_accept) w_state_next = DONE;
            DONE:    w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    assign busy       = w_nz;
    assign drain_done = (r_state == DONE);
    assign err        = r_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios plus random traffic against a count-array model.
module tb_hazard_scoreboard;

    localparam int NREGS = 16;
    localparam int TAGW  = 4;
    localparam int CNTW  = 2;
    localparam int MAXC  = (1 << CNTW) - 1;
`ifdef SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             issue_valid, issue_we;
    logic [TAGW-1:0]  issue_wa3, ra1d, ra2d;
    logic             use1, use2;
    logic             retire_valid;
    logic [TAGW-1:0]  retire_wa3;
    logic             squash_valid;
    logic [TAGW-1:0]  squash_wa3;
    logic             drain_req;
    logic             exe_fwd_valid;
    logic [TAGW-1:0]  exe_fwd_wa3;
    logic             stallD;
    logic [NREGS-1:0] busy;
    logic             drain_done;
    logic             err;

    hazard_scoreboard #(.NREGS(NREGS), .TAGW(TAGW), .CNTW(CNTW)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_we     (issue_we),
        .issue_wa3    (issue_wa3),
        .ra1d         (ra1d),
        .ra2d         (ra2d),
        .use1         (use1),
        .use2         (use2),
        .retire_valid (retire_valid),
        .retire_wa3   (retire_wa3),
        .squash_valid (squash_valid),
        .squash_wa3   (squash_wa3),
        .drain_req    (drain_req),
`ifdef SCOREBOARD_FWD_EN
        .exe_fwd_valid(exe_fwd_valid),
        .exe_fwd_wa3  (exe_fwd_wa3),
`endif
        .stallD       (stallD),
        .busy         (busy),
        .drain_done   (drain_done),
        .err          (err)
    );

    typedef struct packed {
        logic             stall;
        logic [NREGS-1:0] busy;
        logic             done;
        logic             err;
    } exp_t;

    exp_t q[$];
    int   m_cnt [NREGS];
    int   m_phase;          // 0 = issuing, 1 = draining, 2 = drain just finished
    bit   m_err;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [NREGS-1:0] got, input logic [NREGS-1:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("stallD", NREGS'(stallD), NREGS'(e.stall));
            check("busy", busy, e.busy);
            check("drain_done", NREGS'(drain_done), NREGS'(e.done));
            check("err", NREGS'(err), NREGS'(e.err));
        end
    end

    function automatic bit pending(input int idx);
        if (m_cnt[idx] == 0) return 1'b0;
        if (FWD && exe_fwd_valid && int'(exe_fwd_wa3) == idx && m_cnt[idx] == 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic idle();
        issue_valid = 0; issue_we = 0; issue_wa3 = 0;
        ra1d = 0; ra2d = 0; use1 = 0; use2 = 0;
        retire_valid = 0; retire_wa3 = 0;
        squash_valid = 0; squash_wa3 = 0;
        drain_req = 0; exe_fwd_valid = 0; exe_fwd_wa3 = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
        m_phase = 0;
        m_err   = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        model_clear();
    endtask

    // Push the expectation for the current inputs, then advance the model across the edge.
    task automatic step();
        exp_t e;
        bit   acc;
        int   net;
        e.stall = (use1 && pending(int'(ra1d))) || (use2 && pending(int'(ra2d))) ||
                  (issue_we && m_cnt[issue_wa3] == MAXC) || (m_phase != 0);
        for (int i = 0; i < NREGS; i++) e.busy[i] = (m_cnt[i] != 0);
        e.done = (m_phase == 2);
        e.err  = m_err;
        q.push_back(e);
        @(posedge clk);
        acc = issue_valid && issue_we && !e.stall;
        case (m_phase)
            0: if (drain_req) m_phase = 1;
            1: if (e.busy == '0 && !acc) m_phase = 2;
            default: m_phase = 0;
        endcase
        for (int i = 0; i < NREGS; i++) begin
            net = 0;
            if (acc && int'(issue_wa3) == i) net++;
            if (retire_valid && int'(retire_wa3) == i) net--;
            if (squash_valid && int'(squash_wa3) == i) net--;
            if (m_cnt[i] + net < 0) begin
                m_err    = 1;
                m_cnt[i] = 0;
            end else if (m_cnt[i] + net > MAXC) begin
                m_cnt[i] = MAXC;
            end else begin
                m_cnt[i] = m_cnt[i] + net;
            end
        end
        #1;
    endtask

    task automatic issue(input int r);
        idle(); issue_valid = 1; issue_we = 1; issue_wa3 = TAGW'(r);
    endtask

    task automatic retire(input int r);
        idle(); retire_valid = 1; retire_wa3 = TAGW'(r);
    endtask

    function automatic logic [TAGW-1:0] pick();
        return ($urandom_range(0, 9) < 8) ? TAGW'($urandom_range(0, 3)) : TAGW'($urandom_range(0, NREGS - 1));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        model_clear();
        do_reset();
        step();                                  // reset state

        // dependent read of r3, then retire clears it
        issue(3); step();
        idle(); use1 = 1; ra1d = 3; step();
        retire(3); use1 = 1; ra1d = 3; step();
        idle(); use1 = 1; ra1d = 3; step();

        // issue and retire of r5 in the same cycle
        issue(5); step();
        issue(5); retire_valid = 1; retire_wa3 = 5; step();
        idle(); step();
        retire(5); step();

        // r7 saturates after three issues
        repeat (4) begin issue(7); step(); end
        repeat (3) begin retire(7); step(); end
        idle(); use2 = 1; ra2d = 7; step();

        // retire of an idle register sets sticky err
        retire(2); step();
        idle(); step(); step();
        do_reset();
        step();

        // drain with r1, r4 pending
        issue(1); step();
        issue(4); step();
        idle(); drain_req = 1; step();
        issue(8); step();
        retire(1); step();
        idle(); squash_valid = 1; squash_wa3 = 4; step();
        idle(); repeat (4) step();

        // forwarding from Execute for r6
        issue(6); step();
        idle(); use2 = 1; ra2d = 6; exe_fwd_valid = 1; exe_fwd_wa3 = 6; step();
        issue(6); step();
        idle(); use2 = 1; ra2d = 6; exe_fwd_valid = 1; exe_fwd_wa3 = 6; step();
        retire(6); step(); step();
        idle(); step();

        // reset while draining
        issue(9); step();
        idle(); drain_req = 1; step();
        idle(); step();
        do_reset();
        idle(); step();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            idle();
            issue_valid   = ($urandom_range(0, 1) == 1);
            issue_we      = ($urandom_range(0, 3) != 0);
            issue_wa3     = pick();
            ra1d          = pick();
            ra2d          = pick();
            use1          = $urandom_range(0, 1);
            use2          = $urandom_range(0, 1);
            retire_valid  = ($urandom_range(0, 2) == 0);
            retire_wa3    = pick();
            squash_valid  = ($urandom_range(0, 7) == 0);
            squash_wa3    = pick();
            drain_req     = ($urandom_range(0, 49) == 0);
            exe_fwd_valid = $urandom_range(0, 1);
            exe_fwd_wa3   = pick();
            step();
        end

        idle();
        @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
